// File: rtl/mult_div_unit_if.sv
// Core <-> multiply/divide unit bundle: command, operands, Hi/Lo direct
// writes (master = core side) and Busy/Done/DivByZero/Hi/Lo (slave = unit).
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             OpDiv;
  logic             Signed;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             HiWriteEnable;
  logic             LoWriteEnable;
  logic [WIDTH-1:0] WriteData;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, OpDiv, Signed, OperandA, OperandB,
    output HiWriteEnable, LoWriteEnable, WriteData,
    input  Busy, Done, DivByZero, Hi, Lo
  );

  modport slave (
    input  Start, OpDiv, Signed, OperandA, OperandB,
    input  HiWriteEnable, LoWriteEnable, WriteData,
    output Busy, Done, DivByZero, Hi, Lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative WIDTH-cycle shift-add multiplier / restoring divider with HI/LO.
// Ports: clk, rst_n, bus (slave). Signed ops only with MULDIV_SIGNED_EN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mc_q, mc_d;
  logic                 div_q, div_d;
  logic                 nega_q, nega_d;
  logic                 negb_q, negb_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 sgn;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       madd;
  logic [WIDTH:0]       dsub;
  logic [2*WIDTH-1:0]   step;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  assign sgn = bus.Signed;
`else
  logic unused_signed;
  assign sgn = 1'b0;
  assign unused_signed = bus.Signed;
`endif

  // Signed operands are reduced to magnitudes; the core datapath is unsigned.
  assign a_neg = sgn & bus.OperandA[WIDTH-1];
  assign b_neg = sgn & bus.OperandB[WIDTH-1];
  assign a_mag = a_neg ? -bus.OperandA : bus.OperandA;
  assign b_mag = b_neg ? -bus.OperandB : bus.OperandB;

  // Multiply: acc = {partial, multiplier}; add mc on lsb, shift right.
  // Divide:   acc = {remainder, dividend}; trial-subtract mc from the
  //           remainder with the next dividend bit shifted in.
  always_comb begin
    madd = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
         + (acc_q[0] ? {1'b0, mc_q} : '0);
    dsub = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mc_q};
    step = {madd, acc_q[WIDTH-1:1]};
    if (div_q) begin
      if (!dsub[WIDTH]) begin
        step = {dsub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up lands in the same edge as the result load.
  always_comb begin
    prod   = (nega_q ^ negb_q) ? -step : step;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (div_q) begin
      res_lo = (nega_q ^ negb_q) ? -step[WIDTH-1:0] : step[WIDTH-1:0];
      res_hi = nega_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
      // A zero divisor leaves the dividend in the remainder half, so
      // after fix-up Hi is OperandA as given; the quotient is forced.
      if (dz_q) begin
        res_lo = '1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    div_d   = div_q;
    nega_d  = nega_q;
    negb_d  = negb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = bus.OpDiv;
          nega_d  = a_neg;
          negb_d  = b_neg;
          dz_d    = bus.OpDiv & (bus.OperandB == '0);
          if (bus.OpDiv) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            mc_d  = b_mag;
          end else begin
            acc_d = {{WIDTH{1'b0}}, b_mag};
            mc_d  = a_mag;
          end
        end else begin
          if (bus.HiWriteEnable) begin
            hi_d = bus.WriteData;
          end
          if (bus.LoWriteEnable) begin
            lo_d = bus.WriteData;
          end
        end
      end
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          dbz_d   = div_q & dz_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      div_q   <= 1'b0;
      nega_q  <= 1'b0;
      negb_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      div_q   <= div_d;
      nega_q  <= nega_d;
      negb_q  <= negb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.Busy      = (state_q == RUN);
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected Hi/Lo,
// a negedge monitor pops and checks on every Done pulse.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int LAT = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           t0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  int   done_cnt;
  exp_t sb[$];

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.Done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=1 want=0 t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("hi", 64'(bus.Hi), 64'(e.hi));
        chk("lo", 64'(bus.Lo), 64'(e.lo));
        chk("dbz", 64'(bus.DivByZero), 64'(e.dbz));
        chk("latency", 64'(cyc - e.t0), 64'(LAT));
        chk("busy_at_done", 64'(bus.Busy), 64'd0);
      end
    end
  end

  // Drives Start for one edge from the current (negedge) point.
  task automatic issue(input logic div, input logic sg,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input logic edz);
    bus.Start    = 1'b1;
    bus.OpDiv    = div;
    bus.Signed   = sg;
    bus.OperandA = a;
    bus.OperandB = b;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    if (push) sb.push_back('{eh, el, edz, cyc});
    chk("busy_after_start", 64'(bus.Busy), 64'd1);
  endtask

  // Returns at the negedge where Done is high.
  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < LAT + 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.Done) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=0 want=1 t=%0t", $time);
    end
  endtask

  initial begin
    int nd;
    checks   = 0;
    failures = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    bus.Start         = 1'b0;
    bus.OpDiv         = 1'b0;
    bus.Signed        = 1'b0;
    bus.OperandA      = '0;
    bus.OperandB      = '0;
    bus.HiWriteEnable = 1'b0;
    bus.LoWriteEnable = 1'b0;
    bus.WriteData     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_dbz", 64'(bus.DivByZero), 64'd0);
    chk("rst_hi", 64'(bus.Hi), 64'd0);
    chk("rst_lo", 64'(bus.Lo), 64'd0);

    issue(0, 0, 32'd7, 32'd6, 1, 32'd0, 32'h2A, 0);
    wait_done();
    @(negedge clk);
    issue(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
          32'hFFFF_FFFE, 32'h1, 0);
    wait_done();
    @(negedge clk);
    issue(1, 0, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0);
    wait_done();
    @(negedge clk);
    issue(1, 0, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1);
    wait_done();

    // Start while busy is dropped; Start on the Done cycle is taken.
    @(negedge clk);
    issue(0, 0, 32'd3, 32'd5, 1, 32'd0, 32'd15, 0);
    repeat (9) @(negedge clk);
    bus.Start    = 1'b1;
    bus.OpDiv    = 1'b1;
    bus.OperandA = 32'h100;
    bus.OperandB = 32'h100;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done();
    issue(1, 0, 32'd50, 32'd3, 1, 32'd2, 32'd16, 0);
    wait_done();

    // Direct Hi/Lo writes.
    @(negedge clk);
    bus.HiWriteEnable = 1'b1;
    bus.WriteData     = 32'h1234_5678;
    @(negedge clk);
    bus.HiWriteEnable = 1'b0;
    chk("mthi_hi", 64'(bus.Hi), 64'h1234_5678);
    chk("mthi_lo", 64'(bus.Lo), 64'd16);
    bus.HiWriteEnable = 1'b1;
    bus.LoWriteEnable = 1'b1;
    bus.WriteData     = 32'hCAFE_BABE;
    @(negedge clk);
    chk("both_hi", 64'(bus.Hi), 64'hCAFE_BABE);
    chk("both_lo", 64'(bus.Lo), 64'hCAFE_BABE);
    bus.LoWriteEnable = 1'b0;
    bus.WriteData     = 32'h1111_1111;
    issue(0, 0, 32'd2, 32'd3, 1, 32'd0, 32'd6, 0);
    bus.HiWriteEnable = 1'b0;
    chk("write_at_start_hi", 64'(bus.Hi), 64'hCAFE_BABE);
    repeat (3) @(negedge clk);
    bus.HiWriteEnable = 1'b1;
    bus.LoWriteEnable = 1'b1;
    bus.WriteData     = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.HiWriteEnable = 1'b0;
    bus.LoWriteEnable = 1'b0;
    chk("busy_write_hi", 64'(bus.Hi), 64'hCAFE_BABE);
    chk("busy_write_lo", 64'(bus.Lo), 64'hCAFE_BABE);
    wait_done();

    // Reset in the middle of a divide abandons it.
    @(negedge clk);
    issue(1, 0, 32'd1000, 32'd10, 0, '0, '0, 0);
    nd = done_cnt;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.Busy), 64'd0);
    chk("midrst_hi", 64'(bus.Hi), 64'd0);
    chk("midrst_lo", 64'(bus.Lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 8) @(negedge clk);
    chk("no_done_after_rst", 64'(done_cnt), 64'(nd));

`ifdef MULDIV_SIGNED_EN
    issue(1, 1, 32'hFFFF_FFF9, 32'd2, 1,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    wait_done();
    @(negedge clk);
    issue(0, 1, 32'hFFFF_FFFD, 32'd5, 1,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    wait_done();
    @(negedge clk);
    issue(1, 1, 32'hFFFF_FFF9, 32'd0, 1,
          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
    wait_done();
`else
    issue(1, 1, 32'hFFFF_FFF9, 32'd2, 1,
          32'd1, 32'h7FFF_FFFC, 0);
    wait_done();
    @(negedge clk);
    issue(0, 1, 32'hFFFF_FFFD, 32'd5, 1,
          32'd4, 32'hFFFF_FFF1, 0);
    wait_done();
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit sitting directly downstream of the register file.
- Consumes the two register read ports (ReadData1 -> OperandA, ReadData2 -> OperandB) on a Start command.
- Holds results in HI/LO registers that later move-from instructions read.
- Multi-cycle: the core stalls on Busy.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are each WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  launch operation; sampled only while idle
- OpDiv  input  1  0 = multiply, 1 = divide; sampled with Start
- Signed  input  1  signed operation; sampled with Start (see Optional Feature)
- OperandA  input  WIDTH  multiplicand / dividend (from ReadData1)
- OperandB  input  WIDTH  multiplier / divisor (from ReadData2)
- HiWriteEnable  input  1  direct write of Hi (MTHI)
- LoWriteEnable  input  1  direct write of Lo (MTLO)
- WriteData  input  WIDTH  data for direct Hi/Lo write
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse when Hi/Lo receive a result
- DivByZero  output  1  one-cycle pulse alongside Done for a divide with OperandB == 0
- Hi  output  WIDTH  product high half / remainder
- Lo  output  WIDTH  product low half / quotient

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0; counter and working registers cleared.
- Reset mid-operation: operation is abandoned; no Done pulse is issued after reset is released.
- State IDLE:
  - Start=1 at edge N: latch operands, OpDiv and Signed; go to RUN; Busy=1 from edge N.
  - Start=0: stay in IDLE.
- State RUN:
  - One iteration per edge, WIDTH iterations at edges N+1 .. N+WIDTH.
  - At edge N+WIDTH: Hi/Lo load the result, Busy=0, Done=1 for exactly one cycle, return to IDLE.
  - Total latency: Start edge to result edge = WIDTH cycles.
- Multiply: shift-add over 2*WIDTH-bit accumulator; {Hi,Lo} = full 2*WIDTH-bit product, no truncation.
- Divide: restoring, one quotient bit per iteration; Lo = quotient, Hi = remainder.
- Divide by zero:
  - No trap. Lo = all ones, Hi = dividend (unsigned magnitude path).
  - DivByZero pulses with Done.
  - Latency unchanged.
- Start while Busy: ignored; no queueing.
- Start in the cycle Done is high: accepted, since the unit is already IDLE.
- HiWriteEnable/LoWriteEnable:
  - In IDLE with Start=0: Hi/Lo take WriteData at the next edge; both enables may be active together.
  - While Busy, or in the same cycle as an accepted Start: ignored. This write-ordering hazard is the core's responsibility.
- Hi/Lo hold their value between results and direct writes. Working registers are internal and never visible on Hi/Lo before Done.

Optional Feature:
- Macro: MULDIV_SIGNED_EN
- Defined:
  - Signed=1 takes operand magnitudes and runs the unsigned datapath.
  - Product sign = signA XOR signB.
  - Quotient sign = signA XOR signB; remainder sign = dividend sign.
  - Fix-up is applied in the same edge as result load, so latency is still WIDTH.
  - Divide by zero: Lo = all ones, Hi = OperandA as given.
- Not defined: Signed port is present but ignored; all operations are unsigned.

Test Plan:
- Multiply: reset, then Start, OpDiv=0, A=0x0000_0007, B=0x0000_0006 -> Busy high 32 cycles; Done at cycle 32; Hi=0, Lo=0x0000_002A.
- Full-width product: A=0xFFFF_FFFF, B=0xFFFF_FFFF unsigned multiply -> Hi=0xFFFF_FFFE, Lo=0x0000_0001.
- Divide and divide by zero: A=100, B=7 -> Lo=14, Hi=2, DivByZero=0. Then A=5, B=0 -> Lo=0xFFFF_FFFF, Hi=5, DivByZero=1 together with Done.
- Start while Busy: Start pulsed at cycle 10 of a multiply with different operands -> ignored; first result unchanged. Start in the Done cycle -> accepted; second Done 32 cycles later.
- Direct writes: HiWriteEnable=1 with WriteData=0x1234_5678 in IDLE -> Hi=0x1234_5678 next edge. The same write while Busy -> Hi unchanged.
- Reset and signed: rst_n low at cycle 15 of a divide -> Busy=0, Hi=Lo=0 immediately; no Done afterwards. With MULDIV_SIGNED_EN: signed A=-7 (0xFFFF_FFF9), B=2 divide -> Lo=0xFFFF_FFFD (-3), Hi=0xFFFF_FFFF (-1).
